// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle MIPS-subset core (datapath, 32x32 GPR file and
// FSM controller) sharing one req/ack memory port for fetch and data.
module mc_datapath #(
   parameter int unsigned ADDR_W   = 10,
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int unsigned OVF_REG  = 30
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   input  logic [4:0]        dbg_addr,
   output logic [31:0]       dbg_data,
   output logic [31:0]       pc_out,
   output logic [2:0]        state_out,
   output logic              overflow,
   output logic              illegal
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5
   } state_t;

   localparam logic [5:0] OP_R     = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   localparam logic [4:0] OVF_IDX  = OVF_REG[4:0];

   state_t      state;
   logic [31:0] pc, ir, a_reg, b_reg, alu_out, mdr;
   logic [31:0] gpr [0:31];

   // Instruction field views
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   logic [31:0] sext_imm, zext_imm;

   assign op       = ir[31:26];
   assign rs       = ir[25:21];
   assign rt       = ir[20:16];
   assign rd       = ir[15:11];
   assign funct    = ir[5:0];
   assign imm      = ir[15:0];
   assign sext_imm = {{16{imm[15]}}, imm};
   assign zext_imm = {16'h0000, imm};

   logic [31:0] jump_target, branch_target, alu_result, wb_data;
   logic [4:0]  wb_idx;
   logic        legal, addi_ovf;

   // PC is already incremented by the time these targets are used
   assign jump_target   = {pc[31:28], ir[25:0], 2'b00};
   assign branch_target = pc + {sext_imm[29:0], 2'b00};

   // Signed overflow of A + sext(imm); A and ALUOut are both still held in WB
   assign addi_ovf = (a_reg[31] == imm[15]) && (alu_out[31] != a_reg[31]);

   assign wb_idx  = (op == OP_R) ? rd : rt;
   assign wb_data = (op == OP_LW) ? mdr : alu_out;

   // Classify the opcode/funct as supported or not
   always_comb begin
      // NOTE: default first so every path assigns and no latch is inferred.
      legal = 1'b0;
      case (op)
         OP_R:    legal = (funct == FN_ADDU) || (funct == FN_SUBU) ||
                          (funct == FN_SLT)  || (funct == FN_JR);
         OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_ADDIU,
         OP_ORI, OP_LUI, OP_LW, OP_SW:
                  legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   // ALU: sext-immediate add covers addi/addiu/lw/sw address generation
   always_comb begin
      alu_result = a_reg + sext_imm;
      case (op)
         OP_R: begin
            case (funct)
               FN_SUBU: alu_result = a_reg - b_reg;
               FN_SLT:  alu_result = {31'd0, ($signed(a_reg) < $signed(b_reg))};
               default: alu_result = a_reg + b_reg;
            endcase
         end
         OP_ORI:  alu_result = a_reg | zext_imm;
         OP_LUI:  alu_result = {imm, 16'h0000};
         default: alu_result = a_reg + sext_imm;
      endcase
   end

   // Memory port is driven straight from the registered state so that an
   // asynchronous reset drops the request at once
   assign mem_req   = (state == S_FETCH) || (state == S_MEM);
   assign mem_we    = (state == S_MEM) && (op == OP_SW);
   assign mem_addr  = (state == S_MEM) ? alu_out[ADDR_W-1:0] : pc[ADDR_W-1:0];
   assign mem_wdata = b_reg;

   assign dbg_data  = (dbg_addr == 5'd0) ? 32'd0 : gpr[dbg_addr];
   assign pc_out    = pc;
   assign state_out = state;

   // Controller, architectural registers and GPR file
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         pc       <= RESET_PC;
         ir       <= '0;
         a_reg    <= '0;
         b_reg    <= '0;
         alu_out  <= '0;
         mdr      <= '0;
         overflow <= 1'b0;
         illegal  <= 1'b0;
         // NOTE: the GPR file is cleared by reset, so it maps to flops, not RAM.
         for (int i = 0; i < 32; i++) gpr[i] <= '0;
      end else begin
         // NOTE: non-blocking throughout so every read sees pre-edge values.
         overflow <= 1'b0;
         illegal  <= 1'b0;
         case (state)
            S_IDLE: state <= S_FETCH;

            S_FETCH: begin
               if (mem_ack) begin
                  ir    <= mem_rdata;
                  pc    <= pc + 32'd4;
                  state <= S_DECODE;
               end
            end

            S_DECODE: begin
               a_reg <= gpr[rs];
               b_reg <= gpr[rt];
               state <= S_EXEC;
               if (!legal) begin
                  illegal <= 1'b1;
                  state   <= S_FETCH;
               end else if (op == OP_J) begin
                  pc    <= jump_target;
                  state <= S_FETCH;
               end else if (op == OP_JAL) begin
                  pc      <= jump_target;
                  gpr[31] <= pc;
                  state   <= S_FETCH;
               end else if ((op == OP_R) && (funct == FN_JR)) begin
                  pc    <= gpr[rs];
                  state <= S_FETCH;
               end
            end

            S_EXEC: begin
               alu_out <= alu_result;
               case (op)
                  OP_BEQ: begin
                     if (a_reg == b_reg) pc <= branch_target;
                     state <= S_FETCH;
                  end
                  OP_LW, OP_SW: state <= S_MEM;
                  default:      state <= S_WB;
               endcase
            end

            S_MEM: begin
               if (mem_ack) begin
                  if (op == OP_LW) begin
                     mdr   <= mem_rdata;
                     state <= S_WB;
                  end else begin
                     state <= S_FETCH;
                  end
               end
            end

            S_WB: begin
               state <= S_FETCH;
               if ((op == OP_ADDI) && addi_ovf) begin
                  overflow <= 1'b1;
                  if (OVF_IDX != 5'd0) gpr[OVF_IDX] <= 32'd1;
               end else if (wb_idx != 5'd0) begin
                  gpr[wb_idx] <= wb_data;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
